lms_train_ctrl: RTL and testbench

Upstream sequencer for the 4-tap LMS adaptive filter. It accepts a valid/ready sample stream of input and desired samples (Q4.12) and drives the filter's x_in, d_in and mode_train every clock. It watches the filter's registered error, declares convergence after a run of small errors, and switches the filter to filter mode. It also ends training on a sample-count timeout.

---
 rtl/lms_train_ctrl_if.sv | 11 +
 rtl/lms_train_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_lms_train_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lms_train_ctrl_if.sv
// Sample stream into the LMS training sequencer: one input sample and one
// desired sample per transfer, moved on s_valid & s_ready.
interface lms_train_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x;
  logic [15:0] s_d;

  modport master (output s_valid, output s_x, output s_d, input s_ready);
  modport slave  (input s_valid, input s_x, input s_d, output s_ready);
endinterface

// File: rtl/lms_train_ctrl.sv
// lms_train_ctrl: upstream sequencer for the 4-tap LMS adaptive filter.
// Flushes the filter delay line with zeros, feeds training samples while
// watching the filter's registered error, then switches the filter to plain
// filtering once the error has stayed small long enough or the training
// budget runs out.
// Optional build macro LMS_TRAIN_STATS_EN: when defined, train_len latches
// the number of accepted training samples on leaving TRAIN; otherwise
// train_len is tied to zero.
module lms_train_ctrl #(
  parameter logic signed [15:0] ERR_THR   = 16'sd41,
  parameter int unsigned        CONV_CNT  = 32,
  parameter int unsigned        MAX_TRAIN = 4096,
  parameter int unsigned        FLUSH_LEN = 4,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  lms_train_ctrl_if.slave      s_if,
  input  logic [15:0]          err_in,
  output logic [15:0]          x_out,
  output logic [15:0]          d_out,
  output logic                 mode_train,
  output logic                 busy,
  output logic                 converged,
  output logic                 timeout,
  output logic [CNT_W-1:0]     train_len
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAIN = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int unsigned      FLUSH_LAST   = FLUSH_LEN - 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST_C = FLUSH_LAST[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CONV_CNT_C   = CONV_CNT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MAX_TRAIN_C  = MAX_TRAIN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [15:0]      ERR_THR_U    = ERR_THR;

  // Saturating |v| for Q4.12: the most negative code maps to the largest positive.
  function automatic logic [15:0] abs_sat(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'h8000) begin
      r = 16'h7FFF;
    end else if (v[15]) begin
      r = 16'h0000 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] train_cnt_r;
  logic [CNT_W-1:0] conv_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             trn_q_r;
  logic [15:0]      x_out_r;
  logic [15:0]      d_out_r;
  logic             mode_train_r;
  logic             busy_r;
  logic             converged_r;
  logic             timeout_r;

  logic             s_ready_s;
  logic             accept_s;
  logic             eval_s;
  logic             good_s;
  logic [CNT_W-1:0] train_nxt_s;
  logic [CNT_W-1:0] conv_nxt_s;
  logic             conv_hit_s;
  logic             tmo_hit_s;

  assign s_ready_s     = (state_r == ST_TRAIN) || (state_r == ST_RUN);
  assign s_if.s_ready  = s_ready_s;
  assign x_out         = x_out_r;
  assign d_out         = d_out_r;
  assign mode_train    = mode_train_r;
  assign busy          = busy_r;
  assign converged     = converged_r;
  assign timeout       = timeout_r;

  // Next-count and exit-condition decode for the current TRAIN edge.
  always_comb begin
    accept_s    = s_if.s_valid & s_ready_s;
    // The filter's error is registered one clock after it sees a training
    // sample, so only evaluate it two edges after the accepting edge.
    eval_s      = trn_q_r && (state_r == ST_TRAIN);
    good_s      = abs_sat(err_in) <= ERR_THR_U;
    train_nxt_s = train_cnt_r;
    conv_nxt_s  = conv_cnt_r;
    if (accept_s) begin
      train_nxt_s = inc_sat(train_cnt_r);
    end else begin
      train_nxt_s = train_cnt_r;
    end
    if (eval_s) begin
      if (good_s) begin
        conv_nxt_s = inc_sat(conv_cnt_r);
      end else begin
        conv_nxt_s = CNT_ZERO;
      end
    end else begin
      conv_nxt_s = conv_cnt_r;
    end
    conv_hit_s = eval_s && good_s && (conv_nxt_s == CONV_CNT_C);
    tmo_hit_s  = accept_s && (state_r == ST_TRAIN) && (train_nxt_s == MAX_TRAIN_C);
  end

  // Sequencer FSM with registered filter-side outputs and status flags.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r      <= ST_IDLE;
      train_cnt_r  <= CNT_ZERO;
      conv_cnt_r   <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
      trn_q_r      <= 1'b0;
      x_out_r      <= 16'h0000;
      d_out_r      <= 16'h0000;
      mode_train_r <= 1'b0;
      busy_r       <= 1'b0;
      converged_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else if (start) begin
      // Restart from any state; filter weights are left alone.
      state_r      <= ST_FLUSH;
      train_cnt_r  <= CNT_ZERO;
      conv_cnt_r   <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
      trn_q_r      <= 1'b0;
      x_out_r      <= 16'h0000;
      d_out_r      <= 16'h0000;
      mode_train_r <= 1'b0;
      busy_r       <= 1'b1;
      converged_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      trn_q_r <= mode_train_r;
      case (state_r)
        ST_IDLE: begin
          x_out_r      <= 16'h0000;
          d_out_r      <= 16'h0000;
          mode_train_r <= 1'b0;
          busy_r       <= 1'b0;
        end
        ST_FLUSH: begin
          x_out_r      <= 16'h0000;
          d_out_r      <= 16'h0000;
          mode_train_r <= 1'b0;
          busy_r       <= 1'b1;
          if (flush_cnt_r == FLUSH_LAST_C) begin
            state_r     <= ST_TRAIN;
            flush_cnt_r <= CNT_ZERO;
          end else begin
            flush_cnt_r <= inc_sat(flush_cnt_r);
          end
        end
        ST_TRAIN: begin
          train_cnt_r <= train_nxt_s;
          conv_cnt_r  <= conv_nxt_s;
          if (conv_hit_s || tmo_hit_s) begin
            // Leaving TRAIN: this edge already drives filter-mode outputs,
            // and convergence takes priority over timeout.
            state_r      <= ST_RUN;
            busy_r       <= 1'b0;
            converged_r  <= conv_hit_s;
            timeout_r    <= tmo_hit_s & ~conv_hit_s;
            mode_train_r <= 1'b0;
            d_out_r      <= 16'h0000;
            x_out_r      <= accept_s ? s_if.s_x : 16'h0000;
          end else if (accept_s) begin
            busy_r       <= 1'b1;
            x_out_r      <= s_if.s_x;
            d_out_r      <= s_if.s_d;
            mode_train_r <= 1'b1;
          end else begin
            // Bubble: no sample, so the filter must not adapt this clock.
            busy_r       <= 1'b1;
            x_out_r      <= 16'h0000;
            d_out_r      <= 16'h0000;
            mode_train_r <= 1'b0;
          end
        end
        ST_RUN: begin
          busy_r       <= 1'b0;
          mode_train_r <= 1'b0;
          d_out_r      <= 16'h0000;
          x_out_r      <= accept_s ? s_if.s_x : 16'h0000;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          mode_train_r <= 1'b0;
          x_out_r      <= 16'h0000;
          d_out_r      <= 16'h0000;
        end
      endcase
    end
  end

`ifdef LMS_TRAIN_STATS_EN
  logic [CNT_W-1:0] train_len_r;

  // Capture the training length, including the exit-edge sample, on leaving TRAIN.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      train_len_r <= CNT_ZERO;
    end else if (start) begin
      train_len_r <= CNT_ZERO;
    end else if ((state_r == ST_TRAIN) && (conv_hit_s || tmo_hit_s)) begin
      train_len_r <= train_nxt_s;
    end else begin
      train_len_r <= train_len_r;
    end
  end

  assign train_len = train_len_r;
`else
  assign train_len = CNT_ZERO;
`endif

endmodule

// File: tb/tb_lms_train_ctrl.sv
// Directed bench for lms_train_ctrl: a default-parameter instance for the
// convergence scenarios and a MAX_TRAIN=16 instance for timeout/restart.
// Expected filter-side outputs are queued as stimulus is driven and checked
// when the following clock edge produces them.
module tb_lms_train_ctrl;

`ifdef LMS_TRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  lms_train_ctrl_if a_if();
  lms_train_ctrl_if b_if();

  logic        start_a, start_b;
  logic [15:0] err_a, err_b;
  logic [15:0] x_a, d_a, x_b, d_b, tl_a, tl_b;
  logic        m_a, m_b, busy_a, busy_b, conv_a, conv_b, tmo_a, tmo_b;

  lms_train_ctrl dut_a (
    .Clk(Clk), .Rst(Rst), .start(start_a), .s_if(a_if), .err_in(err_a),
    .x_out(x_a), .d_out(d_a), .mode_train(m_a), .busy(busy_a),
    .converged(conv_a), .timeout(tmo_a), .train_len(tl_a)
  );

  lms_train_ctrl #(.MAX_TRAIN(16)) dut_b (
    .Clk(Clk), .Rst(Rst), .start(start_b), .s_if(b_if), .err_in(err_b),
    .x_out(x_b), .d_out(d_b), .mode_train(m_b), .busy(busy_b),
    .converged(conv_b), .timeout(tmo_b), .train_len(tl_b)
  );

  typedef struct packed {
    logic        sel;
    logic [15:0] x;
    logic [15:0] d;
    logic        m;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One clock of stream traffic; run=1 means the edge ends in filter mode.
  task automatic step(input logic sel, input logic v, input logic [15:0] x,
                      input logic [15:0] d, input logic [15:0] err, input logic run);
    exp_t e;
    exp_t got;
    if (!sel) begin
      a_if.s_valid = v; a_if.s_x = x; a_if.s_d = d; err_a = err;
      chk("a_s_ready", {31'd0, a_if.s_ready}, 32'd1);
    end else begin
      b_if.s_valid = v; b_if.s_x = x; b_if.s_d = d; err_b = err;
      chk("b_s_ready", {31'd0, b_if.s_ready}, 32'd1);
    end
    e.sel = sel;
    e.x   = v ? x : 16'h0000;
    e.d   = (v && !run) ? d : 16'h0000;
    e.m   = v && !run;
    sb_q.push_back(e);
    tick();
    a_if.s_valid = 1'b0;
    b_if.s_valid = 1'b0;
    got = sb_q.pop_front();
    if (!got.sel) begin
      chk("a_x_out", {16'd0, x_a}, {16'd0, got.x});
      chk("a_d_out", {16'd0, d_a}, {16'd0, got.d});
      chk("a_mode_train", {31'd0, m_a}, {31'd0, got.m});
    end else begin
      chk("b_x_out", {16'd0, x_b}, {16'd0, got.x});
      chk("b_d_out", {16'd0, d_b}, {16'd0, got.d});
      chk("b_mode_train", {31'd0, m_b}, {31'd0, got.m});
    end
  endtask

  // Pulse start and check the cleared state on the following clock.
  task automatic do_start(input logic sel);
    if (!sel) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    if (!sel) begin
      chk("a_start_busy", {31'd0, busy_a}, 32'd1);
      chk("a_start_conv", {31'd0, conv_a}, 32'd0);
      chk("a_start_tmo", {31'd0, tmo_a}, 32'd0);
      chk("a_start_len", {16'd0, tl_a}, 32'd0);
    end else begin
      chk("b_start_busy", {31'd0, busy_b}, 32'd1);
      chk("b_start_conv", {31'd0, conv_b}, 32'd0);
      chk("b_start_tmo", {31'd0, tmo_b}, 32'd0);
      chk("b_start_len", {16'd0, tl_b}, 32'd0);
    end
  endtask

  // Four flush clocks of zero outputs, then TRAIN with s_ready high.
  task automatic flush_check(input logic sel);
    for (int i = 0; i < 4; i++) begin
      if (!sel) begin
        chk("a_flush_busy", {31'd0, busy_a}, 32'd1);
        chk("a_flush_x", {16'd0, x_a}, 32'd0);
        chk("a_flush_mode", {31'd0, m_a}, 32'd0);
        chk("a_flush_ready", {31'd0, a_if.s_ready}, 32'd0);
      end else begin
        chk("b_flush_busy", {31'd0, busy_b}, 32'd1);
        chk("b_flush_x", {16'd0, x_b}, 32'd0);
        chk("b_flush_mode", {31'd0, m_b}, 32'd0);
        chk("b_flush_ready", {31'd0, b_if.s_ready}, 32'd0);
      end
      tick();
    end
    if (!sel) chk("a_train_ready", {31'd0, a_if.s_ready}, 32'd1);
    else      chk("b_train_ready", {31'd0, b_if.s_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ev;
    int          n;
    Rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    err_a = 16'h0000; err_b = 16'h0000;
    a_if.s_valid = 1'b0; a_if.s_x = 16'h0000; a_if.s_d = 16'h0000;
    b_if.s_valid = 1'b0; b_if.s_x = 16'h0000; b_if.s_d = 16'h0000;
    tick();
    tick();
    Rst = 1'b0;

    // Reset then idle for 20 clocks.
    for (int i = 0; i < 20; i++) begin
      chk("idle_ready", {30'd0, a_if.s_ready, b_if.s_ready}, 32'd0);
      chk("idle_x", {x_a, x_b}, 32'd0);
      chk("idle_d", {d_a, d_b}, 32'd0);
      chk("idle_flags", {24'd0, m_a, m_b, busy_a, busy_b, conv_a, conv_b, tmo_a, tmo_b}, 32'd0);
      chk("idle_len", {tl_a, tl_b}, 32'd0);
      tick();
    end

    // Convergence: err=10 on every evaluation; 32nd evaluation on edge 34.
    do_start(1'b0);
    flush_check(1'b0);
    for (int k = 1; k <= 34; k++) begin
      step(1'b0, 1'b1, 16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'd10, k == 34);
      if (k == 33) chk("a_conv_early", {31'd0, conv_a}, 32'd0);
    end
    chk("a_conv", {31'd0, conv_a}, 32'd1);
    chk("a_conv_tmo", {31'd0, tmo_a}, 32'd0);
    chk("a_conv_busy", {31'd0, busy_a}, 32'd0);
    chk("a_conv_len", {16'd0, tl_a}, STATS ? 32'd34 : 32'd0);
    // Filter mode passthrough with gaps.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'(k % 2 == 0), 16'h0A00 + 16'(k), 16'h0B00, 16'd10, 1'b1);
    end
    chk("a_run_conv_sticky", {31'd0, conv_a}, 32'd1);

    // Run-count reset: bad errors at evaluations 32 (-32768) and 64 (-5000).
    do_start(1'b0);
    flush_check(1'b0);
    for (int e = 1; e <= 98; e++) begin
      n  = e - 2;
      ev = (n == 32) ? 16'h8000 : (n == 64) ? 16'hEC78 : 16'd10;
      step(1'b0, 1'b1, 16'h3000 + 16'(e), 16'h4000 + 16'(e), ev, e == 98);
      if (e < 98) chk("a_rc_conv_early", {31'd0, conv_a}, 32'd0);
    end
    chk("a_rc_conv", {31'd0, conv_a}, 32'd1);
    chk("a_rc_mode", {31'd0, m_a}, 32'd0);
    chk("a_rc_len", {16'd0, tl_a}, STATS ? 32'd98 : 32'd0);

    // Timeout with alternating valid: 16th accept lands on edge 31.
    do_start(1'b1);
    flush_check(1'b1);
    for (int e = 1; e <= 31; e++) begin
      step(1'b1, 1'(e % 2 == 1), 16'h0100 + 16'(e), 16'h0200 + 16'(e), 16'd2000, e == 31);
      if (e < 31) chk("b_tmo_early", {31'd0, tmo_b}, 32'd0);
    end
    chk("b_tmo", {31'd0, tmo_b}, 32'd1);
    chk("b_tmo_conv", {31'd0, conv_b}, 32'd0);
    chk("b_tmo_busy", {31'd0, busy_b}, 32'd0);
    chk("b_tmo_len", {16'd0, tl_b}, STATS ? 32'd16 : 32'd0);

    // Restart mid-TRAIN after 10 accepts, then a full flush.
    do_start(1'b1);
    flush_check(1'b1);
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b1, 16'h0500 + 16'(e), 16'h0600 + 16'(e), 16'd2000, 1'b0);
    end
    chk("b_pre_restart_mode", {31'd0, m_b}, 32'd1);
    do_start(1'b1);
    chk("b_restart_mode", {31'd0, m_b}, 32'd0);
    flush_check(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
